char_row_loader: RTL and testbench

CHAR_ROW_LOADER -- requirements
Module: char_row_loader

---
 rtl/char_row_loader_pkg.sv | 17 +
 rtl/char_row_loader_if.sv | 15 +
 rtl/char_row_loader_sync_bit.sv | 29 ++
 rtl/char_row_loader.sv | 126 ++++++++++++
 tb/tb_char_row_loader.sv | 384 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/char_row_loader_pkg.sv
// Shared constants for the character row loader.
// Opcodes come from bus_data[7:6]. State encodings are plain constants so
// that legacy code comparing raw state values keeps working.
package char_pkg;

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_SETCUR = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_FILL   = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARG  = 2'd1;
  localparam logic [1:0] ST_FILL = 2'd2;

  localparam logic [5:0] BLANK_DEFAULT = 6'h3F;

endpackage

// File: rtl/char_row_loader_if.sv
// Command bus between the Arduino and the row loader (4-phase handshake).
//   bus_data   : command byte, stable while bus_strobe is high
//   bus_strobe : request from the Arduino, asynchronous to clk
//   bus_ack    : acknowledge from the loader
// master = Arduino side, slave = loader side.
interface char_row_loader_if;

  logic [7:0] bus_data;
  logic       bus_strobe;
  logic       bus_ack;

  modport master (output bus_data, output bus_strobe, input bus_ack);
  modport slave  (input bus_data, input bus_strobe, output bus_ack);

endinterface

// File: rtl/char_row_loader_sync_bit.sv
// Single-bit flop synchronizer for the asynchronous bus strobe.
//   clk, rst_n  : clock and synchronous active-low reset (clears every stage)
//   d           : asynchronous input level
//   q           : level after SYNC_STAGES flops
module sync_bit #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stages;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stages <= '0;
    end else begin
      stages[0] <= d;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/char_row_loader.sv
// Decodes command bytes from the Arduino bus and drives writes into a
// character row buffer.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : command bus (slave side), 4-phase strobe/ack handshake
//   char_out   : character code for the row buffer
//   addr_out   : cell index 0..COLS-1
//   write_out  : one-cycle write strobe
//   busy       : high while a CLEAR/FILLARG fill sequence runs
// Commands: 00 WRITE char at cursor (cursor++), 01 SETCUR, 10 CLEAR to BLANK,
// 11 FILLARG (next byte's low six bits fill the whole row).
module char_row_loader
  import char_pkg::*;
#(
  parameter int unsigned COLS        = 16,
  parameter logic [5:0]  BLANK       = BLANK_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  char_row_loader_if.slave   bus,
  output logic [5:0]         char_out,
  output logic [3:0]         addr_out,
  output logic               write_out,
  output logic               busy
);

  localparam logic [3:0] LAST = 4'(COLS - 1);

  logic       strb_s;
  logic [1:0] state;
  logic [3:0] cursor;
  logic       ack;
  logic       accept;
  logic [1:0] opcode;

  sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.bus_strobe),
    .q     (strb_s)
  );

  assign opcode      = bus.bus_data[7:6];
  assign bus.bus_ack = ack;

  // A pending request is simply ignored during FILL; it is taken once the
  // loader is back in IDLE, since the strobe is still high then.
  assign accept = strb_s && !ack && ((state == ST_IDLE) || (state == ST_ARG));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cursor    <= '0;
      ack       <= 1'b0;
      write_out <= 1'b0;
      busy      <= 1'b0;
      char_out  <= '0;
      addr_out  <= '0;
    end else begin
      write_out <= 1'b0;

      if (ack && !strb_s) begin
        ack <= 1'b0;
      end else if (accept) begin
        ack <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (opcode)
              OP_WRITE: begin
                char_out  <= bus.bus_data[5:0];
                addr_out  <= cursor;
                write_out <= 1'b1;
                cursor    <= (cursor == LAST) ? '0 : cursor + 4'd1;
              end
              OP_SETCUR: begin
                cursor <= 4'(32'(bus.bus_data[3:0]) % COLS);
              end
              OP_CLEAR: begin
                state     <= ST_FILL;
                busy      <= 1'b1;
                char_out  <= BLANK;
                addr_out  <= '0;
                write_out <= 1'b1;
              end
              default: begin
                state <= ST_ARG;
              end
            endcase
          end
        end

        ST_ARG: begin
          if (accept) begin
            state     <= ST_FILL;
            busy      <= 1'b1;
            char_out  <= bus.bus_data[5:0];
            addr_out  <= '0;
            write_out <= 1'b1;
          end
        end

        ST_FILL: begin
          // addr_out doubles as the fill index: the cell just written is
          // what is on addr_out now.
          if (addr_out == LAST) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            cursor <= '0;
          end else begin
            addr_out  <= addr_out + 4'd1;
            write_out <= 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_char_row_loader.sv
// Bench for char_row_loader: drives the Arduino side of the handshake,
// records every row-buffer write, and compares against a row-level model.
module tb_char_row_loader;

  localparam int COLS = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] char_out;
  logic [3:0] addr_out;
  logic       write_out;
  logic       busy;

  always #5 clk = ~clk;

  char_row_loader_if bus ();

  char_row_loader #(
    .COLS        (16),
    .BLANK       (6'h3F),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .char_out  (char_out),
    .addr_out  (addr_out),
    .write_out (write_out),
    .busy      (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- monitor ----------------
  logic [9:0] obs[$];            // {addr, char} of each observed write
  int         busy_cnt = 0;
  bit         ack_prev = 0;
  bit         ack_rise_wr = 0;   // write_out level on the cycle ack rose
  int         hold_bad = 0;
  bit         mon_en = 0;
  logic [5:0] prev_char;
  logic [3:0] prev_addr;

  always @(negedge clk) begin
    if (write_out === 1'b1) obs.push_back({addr_out, char_out});
    if (busy === 1'b1) busy_cnt++;
    if (bus.bus_ack === 1'b1 && !ack_prev) ack_rise_wr = (write_out === 1'b1);
    ack_prev = (bus.bus_ack === 1'b1);
    if (mon_en && write_out === 1'b0 &&
        (char_out !== prev_char || addr_out !== prev_addr)) hold_bad++;
    prev_char = char_out;
    prev_addr = addr_out;
  end

  // ---------------- reference model ----------------
  int         m_cursor = 0;
  bit         m_arg = 0;
  logic [9:0] exp_q[$];
  int         exp_busy;
  bit         exp_rise_wr;

  function automatic void model_fill(input logic [5:0] ch);
    for (int c = 0; c < COLS; c++) exp_q.push_back({4'(c), ch});
    exp_busy = COLS;
    m_cursor = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] d);
    logic [1:0] op;
    op = d[7:6];
    exp_busy = 0;
    if (m_arg) begin
      m_arg = 0;
      model_fill(d[5:0]);
      exp_rise_wr = 1;
    end else if (op == 2'd0) begin
      exp_q.push_back({4'(m_cursor), d[5:0]});
      m_cursor = (m_cursor + 1) % COLS;
      exp_rise_wr = 1;
    end else if (op == 2'd1) begin
      m_cursor = int'(d[3:0]) % COLS;
      exp_rise_wr = 0;
    end else if (op == 2'd2) begin
      model_fill(6'h3F);
      exp_rise_wr = 1;
    end else begin
      m_arg = 1;
      exp_rise_wr = 0;
    end
  endfunction

  // ---------------- drivers ----------------
  task automatic handshake(input logic [7:0] d, output bit ok);
    int k;
    ok = 1;
    @(posedge clk); #1;
    bus.bus_data = d;
    bus.bus_strobe = 1'b1;
    k = 0;
    while (bus.bus_ack !== 1'b1 && k < 60) begin @(negedge clk); k++; end
    if (bus.bus_ack !== 1'b1) ok = 0;
    bus.bus_strobe = 1'b0;
    k = 0;
    while (bus.bus_ack !== 1'b0 && k < 60) begin @(negedge clk); k++; end
    if (bus.bus_ack !== 1'b0) ok = 0;
  endtask

  task automatic do_cmd(input logic [7:0] d, output bit ok);
    int k;
    obs.delete();
    busy_cnt = 0;
    ack_rise_wr = 0;
    handshake(d, ok);
    k = 0;
    while (busy === 1'b1 && k < 40) begin @(negedge clk); k++; end
    if (busy !== 1'b0) ok = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic apply_reset();
    mon_en = 0;
    bus.bus_strobe = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    mon_en = 1;
    m_cursor = 0;
    m_arg = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.bus_data = 8'h05;
    bus.bus_strobe = 1'b1;
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.bus_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b want 0", bus.bus_ack); end
    n_cmp++; if (write_out !== 1'b0) begin n_bad++; $display("FAIL reset_write: got %b want 0", write_out); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (char_out !== 6'h00) begin n_bad++; $display("FAIL reset_char: got %h want 00", char_out); end
    n_cmp++; if (addr_out !== 4'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", addr_out); end
    bus.bus_strobe = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++; if (bus.bus_ack !== 1'b0 || write_out !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL post_reset_idle: got ack %b wr %b busy %b want 0 0 0", bus.bus_ack, write_out, busy);
    end
    mon_en = 1;
    m_cursor = 0;
    m_arg = 0;
  endtask

  task automatic test_write_setcur();
    logic [7:0] seq [4] = '{8'h05, 8'h4F, 8'h0A, 8'h0B};
    bit ok;
    for (int s = 0; s < 4; s++) begin
      exp_q.delete();
      model_byte(seq[s]);
      do_cmd(seq[s], ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL ws_handshake[%0d]: byte %h did not complete ack cycle", s, seq[s]); end
      n_cmp++; if (obs.size() != exp_q.size()) begin
        n_bad++; $display("FAIL ws_count[%0d]: got %0d writes want %0d", s, obs.size(), exp_q.size());
      end else begin
        for (int i = 0; i < obs.size(); i++) begin
          n_cmp++; if (obs[i] !== exp_q[i]) begin
            n_bad++; $display("FAIL ws_write[%0d]: got addr %0d char %h want addr %0d char %h",
                              s, obs[i][9:6], obs[i][5:0], exp_q[i][9:6], exp_q[i][5:0]);
          end
        end
      end
      n_cmp++; if (ack_rise_wr !== exp_rise_wr) begin
        n_bad++; $display("FAIL ws_latency[%0d]: write on ack rise %b want %b", s, ack_rise_wr, exp_rise_wr);
      end
    end
  endtask

  task automatic test_clear_fillarg();
    logic [7:0] seq [4] = '{8'h80, 8'hC0, 8'h21, 8'h15};
    bit ok;
    for (int s = 0; s < 4; s++) begin
      exp_q.delete();
      model_byte(seq[s]);
      do_cmd(seq[s], ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL cf_handshake[%0d]: byte %h did not complete", s, seq[s]); end
      n_cmp++; if (busy_cnt != exp_busy) begin
        n_bad++; $display("FAIL cf_busy[%0d]: busy cycles %0d want %0d", s, busy_cnt, exp_busy);
      end
      n_cmp++; if (obs.size() != exp_q.size()) begin
        n_bad++; $display("FAIL cf_count[%0d]: got %0d writes want %0d", s, obs.size(), exp_q.size());
      end else begin
        for (int i = 0; i < obs.size(); i++) begin
          n_cmp++; if (obs[i] !== exp_q[i]) begin
            n_bad++; $display("FAIL cf_write[%0d.%0d]: got addr %0d char %h want addr %0d char %h",
                              s, i, obs[i][9:6], obs[i][5:0], exp_q[i][9:6], exp_q[i][5:0]);
          end
        end
      end
      n_cmp++; if (ack_rise_wr !== exp_rise_wr) begin
        n_bad++; $display("FAIL cf_latency[%0d]: write on ack rise %b want %b", s, ack_rise_wr, exp_rise_wr);
      end
    end
  endtask

  task automatic test_strobe_during_fill();
    bit ok;
    int viol, k;
    bit busy_at_rise;
    // held request during CLEAR
    exp_q.delete();
    model_byte(8'h80);
    model_byte(8'h07);
    obs.delete();
    handshake(8'h80, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL held_clear_hs: CLEAR handshake did not complete"); end
    bus.bus_data = 8'h07;
    bus.bus_strobe = 1'b1;
    viol = 0; k = 0;
    while (bus.bus_ack !== 1'b1 && k < 60) begin
      @(negedge clk); k++;
      if (busy === 1'b1 && bus.bus_ack === 1'b1) viol++;
    end
    busy_at_rise = (busy === 1'b1);
    n_cmp++; if (bus.bus_ack !== 1'b1) begin n_bad++; $display("FAIL held_ack: got %b want 1 after fill", bus.bus_ack); end
    n_cmp++; if (viol != 0 || busy_at_rise) begin
      n_bad++; $display("FAIL held_ack_busy: ack during busy %0d times, busy at ack %b, want 0 and 0", viol, busy_at_rise);
    end
    bus.bus_strobe = 1'b0;
    repeat (6) @(negedge clk);
    n_cmp++; if (obs.size() != exp_q.size()) begin
      n_bad++; $display("FAIL held_count: got %0d writes want %0d", obs.size(), exp_q.size());
    end else begin
      for (int i = 0; i < obs.size(); i++) begin
        n_cmp++; if (obs[i] !== exp_q[i]) begin
          n_bad++; $display("FAIL held_write[%0d]: got addr %0d char %h want addr %0d char %h",
                            i, obs[i][9:6], obs[i][5:0], exp_q[i][9:6], exp_q[i][5:0]);
        end
      end
    end
    // strobe toggled mid-fill, released before the fill ends
    exp_q.delete();
    model_byte(8'h80);
    obs.delete();
    handshake(8'h80, ok);
    bus.bus_data = 8'h3A;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      bus.bus_strobe = ~bus.bus_strobe;
    end
    bus.bus_strobe = 1'b0;
    k = 0;
    while (busy === 1'b1 && k < 40) begin @(negedge clk); k++; end
    repeat (6) @(negedge clk);
    n_cmp++; if (bus.bus_ack !== 1'b0) begin n_bad++; $display("FAIL toggle_ack: got %b want 0", bus.bus_ack); end
    n_cmp++; if (obs.size() != exp_q.size()) begin
      n_bad++; $display("FAIL toggle_count: got %0d writes want %0d", obs.size(), exp_q.size());
    end else begin
      for (int i = 0; i < obs.size(); i++) begin
        n_cmp++; if (obs[i] !== exp_q[i]) begin
          n_bad++; $display("FAIL toggle_write[%0d]: got addr %0d char %h want addr %0d char %h",
                            i, obs[i][9:6], obs[i][5:0], exp_q[i][9:6], exp_q[i][5:0]);
        end
      end
    end
  endtask

  task automatic test_reset_abort();
    bit ok;
    int cnt, k;
    // reset on the 5th FILL cycle
    obs.delete();
    @(posedge clk); #1;
    bus.bus_data = 8'h80;
    bus.bus_strobe = 1'b1;
    cnt = 0; k = 0;
    while (cnt < 5 && k < 60) begin
      @(negedge clk); k++;
      if (busy === 1'b1) cnt++;
    end
    mon_en = 0;
    rst_n = 1'b0;
    bus.bus_strobe = 1'b0;
    @(negedge clk);
    n_cmp++; if (write_out !== 1'b0 || busy !== 1'b0 || bus.bus_ack !== 1'b0) begin
      n_bad++; $display("FAIL abort_outputs: got wr %b busy %b ack %b want 0 0 0", write_out, busy, bus.bus_ack);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    mon_en = 1;
    m_cursor = 0;
    m_arg = 0;
    n_cmp++; if (obs.size() != 5) begin
      n_bad++; $display("FAIL abort_count: got %0d writes want 5", obs.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++; if (obs[i] !== {4'(i), 6'h3F}) begin
          n_bad++; $display("FAIL abort_write[%0d]: got addr %0d char %h want addr %0d char 3f",
                            i, obs[i][9:6], obs[i][5:0], i);
        end
      end
    end
    // cursor back at 0
    exp_q.delete();
    model_byte(8'h15);
    do_cmd(8'h15, ok);
    n_cmp++; if (!ok || obs.size() != 1 || obs[0] !== exp_q[0]) begin
      n_bad++; $display("FAIL abort_cursor: got %0d writes first %h want 1 write %h", obs.size(),
                        (obs.size() > 0) ? obs[0] : 10'h0, exp_q[0]);
    end
    // reset while waiting for the FILLARG argument
    model_byte(8'hC0);
    do_cmd(8'hC0, ok);
    apply_reset();
    exp_q.delete();
    model_byte(8'h21);
    do_cmd(8'h21, ok);
    n_cmp++; if (!ok || obs.size() != 1 || obs[0] !== exp_q[0]) begin
      n_bad++; $display("FAIL arg_abort: got %0d writes first %h want 1 write %h", obs.size(),
                        (obs.size() > 0) ? obs[0] : 10'h0, exp_q[0]);
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [7:0] d;
    int r;
    for (int s = 0; s < 40; s++) begin
      r = int'($urandom_range(0, 99));
      if (r < 50)      d = {2'b00, 6'($urandom_range(0, 63))};
      else if (r < 70) d = {2'b01, 6'($urandom_range(0, 63))};
      else if (r < 85) d = {2'b10, 6'($urandom_range(0, 63))};
      else             d = {2'b11, 6'($urandom_range(0, 63))};
      exp_q.delete();
      model_byte(d);
      do_cmd(d, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL rnd_handshake[%0d]: byte %h did not complete", s, d); end
      n_cmp++; if (busy_cnt != exp_busy) begin
        n_bad++; $display("FAIL rnd_busy[%0d]: byte %h busy cycles %0d want %0d", s, d, busy_cnt, exp_busy);
      end
      n_cmp++; if (obs.size() != exp_q.size()) begin
        n_bad++; $display("FAIL rnd_count[%0d]: byte %h got %0d writes want %0d", s, d, obs.size(), exp_q.size());
      end else begin
        for (int i = 0; i < obs.size(); i++) begin
          n_cmp++; if (obs[i] !== exp_q[i]) begin
            n_bad++; $display("FAIL rnd_write[%0d.%0d]: byte %h got addr %0d char %h want addr %0d char %h",
                              s, i, d, obs[i][9:6], obs[i][5:0], exp_q[i][9:6], exp_q[i][5:0]);
          end
        end
      end
      n_cmp++; if (ack_rise_wr !== exp_rise_wr) begin
        n_bad++; $display("FAIL rnd_latency[%0d]: byte %h write on ack rise %b want %b", s, d, ack_rise_wr, exp_rise_wr);
      end
    end
  endtask

  task automatic test_hold();
    n_cmp++; if (hold_bad != 0) begin
      n_bad++; $display("FAIL hold: char/addr changed without write %0d times, want 0", hold_bad);
    end
  endtask

  initial begin
    bus.bus_data = 8'h00;
    bus.bus_strobe = 1'b0;
    test_reset();
    test_write_setcur();
    test_clear_fillarg();
    test_strobe_during_fill();
    test_reset_abort();
    test_random();
    test_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule
